lot_occupancy_tracker: RTL and testbench

Multi-gate parking-lot occupancy tracker. Each gate has an outer/inner photo-sensor pair, and a per-gate direction FSM turns complete pass-through sequences into enter/exit events. The events are summed each cycle into a saturating occupancy count bounded by a parametrised capacity. The block sits between the synchronised sensor inputs and the display/status logic, and supplies count, full/empty flags and sticky error flags.

---
 rtl/lot_pkg.sv | 20 ++
 rtl/gate_direction_fsm.sv | 77 +++++++
 rtl/lot_occupancy_tracker.sv | 82 ++++++++
 tb/tb_lot_occupancy_tracker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lot_pkg.sv
// Shared types for the parking-lot occupancy tracker: gate FSM states and
// the {outer, inner} sensor patterns a car produces while passing a gate.
package lot_pkg;

    typedef enum logic [2:0] {
        G_IDLE,
        G_IN1,
        G_IN2,
        G_IN3,
        G_OUT1,
        G_OUT2,
        G_OUT3
    } gate_state_t;

    localparam logic [1:0] SENS_NONE  = 2'b00;
    localparam logic [1:0] SENS_OUTER = 2'b10;
    localparam logic [1:0] SENS_BOTH  = 2'b11;
    localparam logic [1:0] SENS_INNER = 2'b01;

endpackage

// File: rtl/gate_direction_fsm.sv
// Per-gate direction tracker: turns a complete outer/inner beam sequence into
// a one-cycle enter or exit pulse; backing up steps one state back.
module gate_direction_fsm
    import lot_pkg::*;
(
    input  logic clk,
    input  logic Reset,
    input  logic sens_out,
    input  logic sens_in,
    output logic enter_evt,
    output logic exit_evt
);

    gate_state_t state;
    logic [1:0]  pat;

    assign pat = {sens_out, sens_in};

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= G_IDLE;
            enter_evt <= 1'b0;
            exit_evt  <= 1'b0;
        end else begin
            enter_evt <= 1'b0;
            exit_evt  <= 1'b0;
            // Any pattern not listed for a state is an aborted pass.
            case (state)
                G_IDLE: begin
                    if (pat == SENS_OUTER)      state <= G_IN1;
                    else if (pat == SENS_INNER) state <= G_OUT1;
                    else                        state <= G_IDLE;
                end
                G_IN1: begin
                    if (pat == SENS_OUTER)     state <= G_IN1;
                    else if (pat == SENS_BOTH) state <= G_IN2;
                    else                       state <= G_IDLE;
                end
                G_IN2: begin
                    if (pat == SENS_BOTH)       state <= G_IN2;
                    else if (pat == SENS_OUTER) state <= G_IN1;
                    else if (pat == SENS_INNER) state <= G_IN3;
                    else                        state <= G_IDLE;
                end
                G_IN3: begin
                    if (pat == SENS_INNER)     state <= G_IN3;
                    else if (pat == SENS_BOTH) state <= G_IN2;
                    else begin
                        state     <= G_IDLE;
                        enter_evt <= (pat == SENS_NONE);
                    end
                end
                G_OUT1: begin
                    if (pat == SENS_INNER)     state <= G_OUT1;
                    else if (pat == SENS_BOTH) state <= G_OUT2;
                    else                       state <= G_IDLE;
                end
                G_OUT2: begin
                    if (pat == SENS_BOTH)       state <= G_OUT2;
                    else if (pat == SENS_INNER) state <= G_OUT1;
                    else if (pat == SENS_OUTER) state <= G_OUT3;
                    else                        state <= G_IDLE;
                end
                G_OUT3: begin
                    if (pat == SENS_OUTER)     state <= G_OUT3;
                    else if (pat == SENS_BOTH) state <= G_OUT2;
                    else begin
                        state    <= G_IDLE;
                        exit_evt <= (pat == SENS_NONE);
                    end
                end
                default: state <= G_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lot_occupancy_tracker.sv
// Multi-gate occupancy counter: sums per-gate enter/exit pulses each cycle into
// a count clamped to [0, CAPACITY], with sticky overflow/underflow flags.
module lot_occupancy_tracker
    import lot_pkg::*;
#(
    parameter  int CAPACITY = 25,
    parameter  int N_GATES  = 2,
    localparam int CW       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [N_GATES-1:0] sens_out,
    input  logic [N_GATES-1:0] sens_in,
    input  logic               clr_err,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic [N_GATES-1:0] enter_evt,
    output logic [N_GATES-1:0] exit_evt,
    output logic               ovf_err,
    output logic               unf_err
);

    localparam logic signed [CW+4:0] CAP_S = (CW + 5)'(CAPACITY);

    logic                  rst_sync;
    logic [3:0]            n_in;
    logic [3:0]            n_out;
    logic signed [CW+4:0]  next_v;
    logic                  clamp_hi;
    logic                  clamp_lo;

    // Assert immediately, release one edge after Reset rises.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) rst_sync <= 1'b0;
        else        rst_sync <= 1'b1;
    end

    for (genvar g = 0; g < N_GATES; g++) begin : g_gate
        gate_direction_fsm u_fsm (
            .clk       (clk),
            .Reset     (rst_sync),
            .sens_out  (sens_out[g]),
            .sens_in   (sens_in[g]),
            .enter_evt (enter_evt[g]),
            .exit_evt  (exit_evt[g])
        );
    end

    // Entries and exits net out before the clamp is applied.
    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < N_GATES; i++) begin
            n_in  = n_in  + {3'b000, enter_evt[i]};
            n_out = n_out + {3'b000, exit_evt[i]};
        end
        next_v   = $signed({5'b00000, count})
                 + $signed({{(CW + 1){1'b0}}, n_in})
                 - $signed({{(CW + 1){1'b0}}, n_out});
        clamp_lo = next_v[CW+4];
        clamp_hi = !clamp_lo && (next_v > CAP_S);
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (clamp_hi)      count <= CW'(CAPACITY);
            else if (clamp_lo) count <= '0;
            else               count <= next_v[CW-1:0];
            ovf_err <= (ovf_err && !clr_err) || clamp_hi;
            unf_err <= (unf_err && !clr_err) || clamp_lo;
        end
    end

    assign full  = (count == CW'(CAPACITY));
    assign empty = (count == '0);

endmodule

// File: tb/tb_lot_occupancy_tracker.sv
// Bench for lot_occupancy_tracker: directed scenarios then a random walk of
// sensor patterns, checked every cycle against a path-position reference model.
module tb_lot_occupancy_tracker;

    localparam int CAPACITY = 25;
    localparam int N_GATES  = 2;
    localparam int CW       = $clog2(CAPACITY + 1);

    logic               clk = 1'b0;
    logic               Reset;
    logic [N_GATES-1:0] sens_out;
    logic [N_GATES-1:0] sens_in;
    logic               clr_err;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic [N_GATES-1:0] enter_evt;
    logic [N_GATES-1:0] exit_evt;
    logic               ovf_err;
    logic               unf_err;

    always #5 clk = ~clk;

    lot_occupancy_tracker #(.CAPACITY(CAPACITY), .N_GATES(N_GATES)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .sens_out  (sens_out),
        .sens_in   (sens_in),
        .clr_err   (clr_err),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .enter_evt (enter_evt),
        .exit_evt  (exit_evt),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: each gate is a position 0..3 along its direction's
    // pattern path (dir 1 = entry, 2 = exit, 0 = idle).
    int               m_pos[N_GATES];
    int               m_dir[N_GATES];
    int               m_count;
    bit               m_ovf;
    bit               m_unf;
    bit [N_GATES-1:0] m_ent;
    bit [N_GATES-1:0] m_ext;
    bit               m_skip;

    function automatic logic [1:0] path_pat(input int d, input int p);
        logic [1:0] ent_path[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        logic [1:0] ext_path[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        if (d == 1) return ent_path[p];
        if (d == 2) return ext_path[p];
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N_GATES; g++) begin
            m_pos[g] = 0;
            m_dir[g] = 0;
        end
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_ent   = '0;
        m_ext   = '0;
    endtask

    task automatic model_edge();
        int         nxt;
        logic [1:0] pat;
        nxt = m_count + $countones(m_ent) - $countones(m_ext);
        if (clr_err) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (nxt > CAPACITY) begin
            m_count = CAPACITY;
            m_ovf   = 1'b1;
        end else if (nxt < 0) begin
            m_count = 0;
            m_unf   = 1'b1;
        end else begin
            m_count = nxt;
        end
        m_ent = '0;
        m_ext = '0;
        for (int g = 0; g < N_GATES; g++) begin
            pat = {sens_out[g], sens_in[g]};
            if (m_pos[g] == 0) begin
                if (pat == 2'b10) begin
                    m_dir[g] = 1;
                    m_pos[g] = 1;
                end else if (pat == 2'b01) begin
                    m_dir[g] = 2;
                    m_pos[g] = 1;
                end
            end else if (pat == path_pat(m_dir[g], m_pos[g])) begin
                m_pos[g] = m_pos[g];
            end else if (pat == path_pat(m_dir[g], m_pos[g] - 1)) begin
                m_pos[g] = m_pos[g] - 1;
            end else if (m_pos[g] < 3 && pat == path_pat(m_dir[g], m_pos[g] + 1)) begin
                m_pos[g] = m_pos[g] + 1;
            end else begin
                if (m_pos[g] == 3 && pat == 2'b00) begin
                    if (m_dir[g] == 1) m_ent[g] = 1'b1;
                    else               m_ext[g] = 1'b1;
                end
                m_pos[g] = 0;
            end
            if (m_pos[g] == 0) m_dir[g] = 0;
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == CAPACITY));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("enter_evt", 32'(enter_evt), 32'(m_ent));
        chk("exit_evt", 32'(exit_evt), 32'(m_ext));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!Reset)      model_reset();
        else if (m_skip) m_skip = 1'b0;
        else             model_edge();
        #1;
        check_all();
    endtask

    task automatic set_pat(input int g, input logic [1:0] p);
        sens_out[g] = p[1];
        sens_in[g]  = p[0];
    endtask

    // Drives a full pass on each gate in lockstep (d: 0 idle, 1 entry, 2 exit).
    task automatic run_seqs(input int d0, input int d1);
        for (int p = 1; p <= 3; p++) begin
            set_pat(0, path_pat(d0, p));
            set_pat(1, path_pat(d1, p));
            tick();
        end
        set_pat(0, 2'b00);
        set_pat(1, 2'b00);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pat;
        int         r;

        Reset    = 1'b0;
        sens_out = '0;
        sens_in  = '0;
        clr_err  = 1'b0;
        m_skip   = 1'b0;
        model_reset();

        repeat (2) tick();
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        Reset  = 1'b1;
        m_skip = 1'b1;
        repeat (2) tick();

        run_seqs(1, 0);
        chk("entry_pulse", 32'(enter_evt), 32'd1);
        tick();
        chk("entry_count", 32'(count), 32'd1);
        chk("entry_empty", 32'(empty), 32'd0);

        run_seqs(0, 2);
        chk("exit_pulse", 32'(exit_evt), 32'd2);
        tick();
        chk("exit_count", 32'(count), 32'd0);
        chk("exit_empty", 32'(empty), 32'd1);
        chk("exit_unf", 32'(unf_err), 32'd0);

        set_pat(0, 2'b10); tick();
        set_pat(0, 2'b11); tick();
        set_pat(0, 2'b10); tick();
        set_pat(0, 2'b00); tick();
        chk("backout_evt", 32'(enter_evt), 32'd0);
        tick();
        chk("backout_count", 32'(count), 32'd0);

        repeat (CAPACITY) run_seqs(1, 0);
        tick();
        chk("fill_count", 32'(count), 32'(CAPACITY));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(ovf_err), 32'd0);
        run_seqs(1, 0);
        tick();
        chk("over_count", 32'(count), 32'(CAPACITY));
        chk("over_ovf", 32'(ovf_err), 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_ovf", 32'(ovf_err), 32'd0);
        run_seqs(1, 0);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_vs_set_ovf", 32'(ovf_err), 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        run_seqs(1, 2);
        tick();
        chk("net_full_count", 32'(count), 32'(CAPACITY));
        chk("net_full_ovf", 32'(ovf_err), 32'd0);

        repeat (12) run_seqs(2, 2);
        run_seqs(0, 2);
        tick();
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_unf", 32'(unf_err), 32'd0);
        run_seqs(2, 2);
        tick();
        chk("under_count", 32'(count), 32'd0);
        chk("under_unf", 32'(unf_err), 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;

        repeat (3) run_seqs(1, 1);
        run_seqs(1, 0);
        tick();
        chk("seven_count", 32'(count), 32'd7);
        set_pat(0, 2'b10); tick();
        set_pat(0, 2'b11); tick();
        #3;
        Reset = 1'b0;
        #1;
        model_reset();
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        repeat (2) tick();
        Reset  = 1'b1;
        m_skip = 1'b1;
        tick();
        set_pat(0, 2'b01); tick();
        set_pat(0, 2'b00); tick();
        chk("post_reset_evt", 32'(enter_evt), 32'd0);
        tick();
        chk("post_reset_count", 32'(count), 32'd0);

        repeat (600) begin
            for (int g = 0; g < N_GATES; g++) begin
                r = $urandom_range(0, 9);
                if (r <= 5) begin
                    if (m_pos[g] == 0)      pat = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                    else if (m_pos[g] == 3) pat = 2'b00;
                    else                    pat = path_pat(m_dir[g], m_pos[g] + 1);
                end else if (r == 6) begin
                    pat = path_pat(m_dir[g], m_pos[g]);
                end else if (r == 7) begin
                    pat = (m_pos[g] > 0) ? path_pat(m_dir[g], m_pos[g] - 1) : 2'b00;
                end else begin
                    pat = 2'($urandom_range(0, 3));
                end
                set_pat(g, pat);
            end
            clr_err = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr_err  = 1'b0;
        sens_out = '0;
        sens_in  = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
